// File: rtl/reg_bus_ctrl_pkg.sv
// Shared definitions for the register-bus controller: widths, opcodes,
// FSM state encoding and a small decision helper.
package reg_bus_ctrl_pkg;

   localparam int W_DEF    = 16;
   localparam int NREG_DEF = 8;
   localparam int IDX_W    = 3;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_MOVE = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;
   localparam logic [1:0] OP_SWAP = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR1  = 3'd2,
      ST_WR2  = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   // MOVE/SWAP between distinct registers are the only read ops that write back
   function automatic logic needs_write(input logic [1:0]       op,
                                        input logic [IDX_W-1:0] src,
                                        input logic [IDX_W-1:0] dst);
      return ((op == OP_MOVE) || (op == OP_SWAP)) && (src != dst);
   endfunction

endpackage

// File: rtl/reg_bus_ctrl_dec3to8.sv
// 3-bit index to one-hot 8 decoder with enable; all-zero when disabled.
module dec3to8 (
   input  logic       en,
   input  logic [2:0] idx,
   output logic [7:0] onehot
);

   // one bit set at idx when enabled, otherwise nothing selected
   always_comb begin
      onehot = 8'd0;
      if (en) begin
         onehot[idx] = 1'b1;
      end else begin
         onehot = 8'd0;
      end
   end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Register-bus controller: accepts LOAD/MOVE/READ/SWAP commands and
// sequences one-hot select/enable pulses onto a bank of registers sharing
// one write bus and two read buses.
module reg_bus_ctrl
   import reg_bus_ctrl_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [IDX_W-1:0] cmd_src,
   input  logic [IDX_W-1:0] cmd_dst,
   input  logic [W-1:0]     cmd_imm,
   output logic [NREG-1:0]  reg_en,
   output logic [NREG-1:0]  reg_selA,
   output logic [NREG-1:0]  reg_selB,
   output logic [W-1:0]     reg_d,
   input  logic [W-1:0]     bus_a,
   input  logic [W-1:0]     bus_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_a,
   output logic [W-1:0]     rsp_b
);

   state_t           state_r;
   logic [1:0]       op_r;
   logic [IDX_W-1:0] src_r;
   logic [IDX_W-1:0] dst_r;
   logic             wen_r;
   logic [IDX_W-1:0] wen_idx_r;
   logic             sel_en_r;
   logic [W-1:0]     reg_d_r;
   logic [W-1:0]     rsp_a_r;
   logic [W-1:0]     rsp_b_r;
   logic             rsp_valid_r;
   logic             cmd_ready_r;
   logic [7:0]       en_oh_s;
   logic [7:0]       sela_oh_s;
   logic [7:0]       selb_oh_s;

   // Sequencer: every output-facing control is a flop set on entry to the
   // state it belongs to, so pulses line up exactly with RD/WR1/WR2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         op_r        <= OP_LOAD;
         src_r       <= 3'd0;
         dst_r       <= 3'd0;
         wen_r       <= 1'b0;
         wen_idx_r   <= 3'd0;
         sel_en_r    <= 1'b0;
         reg_d_r     <= {W{1'b0}};
         rsp_a_r     <= {W{1'b0}};
         rsp_b_r     <= {W{1'b0}};
         rsp_valid_r <= 1'b0;
         cmd_ready_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_r        <= cmd_op;
                  src_r       <= cmd_src;
                  dst_r       <= cmd_dst;
                  cmd_ready_r <= 1'b0;
                  if (cmd_op == OP_LOAD) begin
                     // LOAD answers with the immediate and a zero B word
                     state_r   <= ST_WR1;
                     wen_r     <= 1'b1;
                     wen_idx_r <= cmd_dst;
                     reg_d_r   <= cmd_imm;
                     rsp_a_r   <= cmd_imm;
                     rsp_b_r   <= {W{1'b0}};
                  end else begin
                     state_r  <= ST_RD;
                     sel_en_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RD: begin
               sel_en_r <= 1'b0;
               rsp_a_r  <= bus_a;
               rsp_b_r  <= bus_b;
               if (needs_write(op_r, src_r, dst_r)) begin
                  state_r   <= ST_WR1;
                  wen_r     <= 1'b1;
                  wen_idx_r <= dst_r;
                  reg_d_r   <= bus_a;
               end else begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
               end
            end
            ST_WR1: begin
               if (op_r == OP_SWAP) begin
                  // second half of the swap: old B contents into src
                  state_r   <= ST_WR2;
                  wen_r     <= 1'b1;
                  wen_idx_r <= src_r;
                  reg_d_r   <= rsp_b_r;
               end else begin
                  state_r     <= ST_RESP;
                  wen_r       <= 1'b0;
                  reg_d_r     <= {W{1'b0}};
                  rsp_valid_r <= 1'b1;
               end
            end
            ST_WR2: begin
               state_r     <= ST_RESP;
               wen_r       <= 1'b0;
               reg_d_r     <= {W{1'b0}};
               rsp_valid_r <= 1'b1;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               wen_r       <= 1'b0;
               sel_en_r    <= 1'b0;
               reg_d_r     <= {W{1'b0}};
               rsp_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
            end
         endcase
      end
   end

   dec3to8 u_dec_en (
      .en     (wen_r),
      .idx    (wen_idx_r),
      .onehot (en_oh_s)
   );

   dec3to8 u_dec_sela (
      .en     (sel_en_r),
      .idx    (src_r),
      .onehot (sela_oh_s)
   );

   dec3to8 u_dec_selb (
      .en     (sel_en_r),
      .idx    (dst_r),
      .onehot (selb_oh_s)
   );

   assign reg_en    = en_oh_s[NREG-1:0];
   assign reg_selA  = sela_oh_s[NREG-1:0];
   assign reg_selB  = selb_oh_s[NREG-1:0];
   assign reg_d     = reg_d_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_a     = rsp_a_r;
   assign rsp_b     = rsp_b_r;
   assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Directed bench for reg_bus_ctrl with an 8 x reg16 bank on shared buses.
module tb_reg_bus_ctrl;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_src;
   logic [2:0]  cmd_dst;
   logic [15:0] cmd_imm;
   logic [7:0]  reg_en;
   logic [7:0]  reg_selA;
   logic [7:0]  reg_selB;
   logic [15:0] reg_d;
   logic [15:0] bus_a;
   logic [15:0] bus_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_a;
   logic [15:0] rsp_b;

   logic [15:0] regs [8];

   int tests;
   int fails;

   reg_bus_ctrl #(.W(16), .NREG(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_imm   (cmd_imm),
      .reg_en    (reg_en),
      .reg_selA  (reg_selA),
      .reg_selB  (reg_selB),
      .reg_d     (reg_d),
      .bus_a     (bus_a),
      .bus_b     (bus_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_a     (rsp_a),
      .rsp_b     (rsp_b)
   );

   // clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // eight reg16 instances: write on enable
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (reg_en[i]) regs[i] <= reg_d;
      end
   end

   // shared read buses driven by the selected register
   always_comb begin
      bus_a = 16'h0000;
      bus_b = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (reg_selA[i]) bus_a = bus_a | regs[i];
         if (reg_selB[i]) bus_b = bus_b | regs[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] src,
                        input logic [2:0] dst, input logic [15:0] imm);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_src   = src;
      cmd_dst   = dst;
      cmd_imm   = imm;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      check("ready_back", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_src   = 3'd0;
      cmd_dst   = 3'd0;
      cmd_imm   = 16'h0000;
      rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_reg_en", {24'd0, reg_en}, 32'd0);
      check("rst_sel", {16'd0, reg_selA, reg_selB}, 32'd0);
      check("rst_rsp", {rsp_a, rsp_b}, 32'd0);
      rst = 1'b1;
      tick();
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // LOAD r3 = F0F0
      issue(2'b00, 3'd0, 3'd3, 16'hF0F0);
      check("ld_en", {24'd0, reg_en}, 32'h08);
      check("ld_d", {16'd0, reg_d}, 32'hF0F0);
      check("ld_busy", {30'd0, cmd_ready, rsp_valid}, 32'd0);
      tick();
      check("ld_en_off", {24'd0, reg_en}, 32'd0);
      check("ld_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("ld_rsp", {rsp_a, rsp_b}, 32'hF0F0_0000);
      check("ld_r3", {16'd0, regs[3]}, 32'hF0F0);
      consume();

      // READ 3,3: both ports on the same register
      issue(2'b10, 3'd3, 3'd3, 16'h0000);
      check("rd33_sel", {16'd0, reg_selA, reg_selB}, 32'h0808);
      check("rd33_en", {24'd0, reg_en}, 32'd0);
      tick();
      check("rd33_sel_off", {16'd0, reg_selA, reg_selB}, 32'd0);
      check("rd33_rsp", {rsp_a, rsp_b}, 32'hF0F0_F0F0);
      check("rd33_valid", {31'd0, rsp_valid}, 32'd1);
      consume();

      // LOAD r1 = CCCC, r2 = 1234
      issue(2'b00, 3'd0, 3'd1, 16'hCCCC);
      tick();
      consume();
      issue(2'b00, 3'd0, 3'd2, 16'h1234);
      tick();
      consume();

      // SWAP 1,2
      issue(2'b11, 3'd1, 3'd2, 16'h0000);
      check("sw_rd_sel", {16'd0, reg_selA, reg_selB}, 32'h0204);
      tick();
      check("sw_wr1", {8'd0, reg_en, reg_d}, 32'h04_CCCC);
      check("sw_wr1_sel", {16'd0, reg_selA, reg_selB}, 32'd0);
      tick();
      check("sw_wr2", {8'd0, reg_en, reg_d}, 32'h02_1234);
      check("sw_wr2_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("sw_valid", {31'd0, rsp_valid}, 32'd1);
      check("sw_rsp", {rsp_a, rsp_b}, 32'hCCCC_1234);
      check("sw_idle_bus", {8'd0, reg_en, reg_d}, 32'd0);
      consume();
      issue(2'b10, 3'd1, 3'd2, 16'h0000);
      tick();
      check("sw_readback", {rsp_a, rsp_b}, 32'h1234_CCCC);
      consume();

      // MOVE 5,5: no write states
      issue(2'b01, 3'd5, 3'd5, 16'h0000);
      check("mv55_en_c1", {24'd0, reg_en}, 32'd0);
      check("mv55_sel", {16'd0, reg_selA, reg_selB}, 32'h2020);
      tick();
      check("mv55_en_c2", {24'd0, reg_en}, 32'd0);
      check("mv55_valid", {31'd0, rsp_valid}, 32'd1);
      consume();

      // MOVE 2 -> 3: response carries pre-write contents
      issue(2'b01, 3'd2, 3'd3, 16'h0000);
      tick();
      check("mv_wr1", {8'd0, reg_en, reg_d}, 32'h08_CCCC);
      tick();
      check("mv_valid", {31'd0, rsp_valid}, 32'd1);
      check("mv_rsp", {rsp_a, rsp_b}, 32'hCCCC_F0F0);
      check("mv_r3", {16'd0, regs[3]}, 32'hCCCC);
      consume();

      // READ 1,2 then stall the response while offering another command
      issue(2'b10, 3'd1, 3'd2, 16'h0000);
      tick();
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_dst   = 3'd0;
      cmd_imm   = 16'hABCD;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid_ready", {30'd0, rsp_valid, cmd_ready}, 32'h2);
         check("hold_rsp", {rsp_a, rsp_b}, 32'h1234_CCCC);
         check("hold_en", {24'd0, reg_en}, 32'd0);
         tick();
      end
      cmd_valid = 1'b0;
      consume();
      tick();
      check("hold_ignored", {30'd0, rsp_valid, cmd_ready}, 32'h1);

      // reset in the middle of SWAP WR1 (before its closing edge)
      issue(2'b11, 3'd1, 3'd2, 16'h0000);
      tick();
      check("rsw_wr1", {24'd0, reg_en}, 32'h04);
      rst = 1'b0;
      #1;
      check("rsw_zero_en", {8'd0, reg_en, reg_d}, 32'd0);
      check("rsw_zero_rsp", {15'd0, rsp_valid, rsp_a}, 32'd0);
      tick();
      rst = 1'b1;
      check("rsw_ready", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("rsw_no_pulse", {24'd0, reg_en}, 32'd0);
         tick();
      end
      check("rsw_regs", {regs[1], regs[2]}, 32'h1234_CCCC);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
